// File: rtl/paridade_pkg.sv
// paridade_pkg: shared types, mode constants and the parity helper used by the
// frame parity generator/checker (paridade_quadro) and its word-parity unit.
package paridade_pkg;

    // Frame FSM: no frame open / frame open
    typedef enum logic {
        OCIOSO = 1'b0,
        QUADRO = 1'b1
    } estado_t;

    localparam logic MODO_PAR   = 1'b0;  // even parity
    localparam logic MODO_IMPAR = 1'b1;  // odd parity

    // Widest word the helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int unsigned PAR_MAX_W = 256;

    // Parity bit that makes (data, bit) even (modo=0) or odd (modo=1).
    function automatic logic paridade(input logic [PAR_MAX_W-1:0] data,
                                      input logic                 modo);
        return (^data) ^ modo;
    endfunction

endpackage

// File: rtl/paridade_palavra.sv
// paridade_palavra: combinational WIDTH-bit word parity with selectable mode.
// Ports:
//   data  - word to protect
//   modo  - 0 even, 1 odd
//   par_c - parity bit (combinational)
module paridade_palavra
    import paridade_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             modo,
    output logic             par_c
);

    assign par_c = paridade(PAR_MAX_W'(data), modo);

endmodule

// File: rtl/paridade_quadro.sv
// paridade_quadro: pipelined parity generator/checker for framed word streams.
// Forwards each accepted word with its parity bit through one output register,
// accumulates a frame parity bit, counts words per frame (force-closing at
// MAX_FRAME) and, when PARIDADE_CHECK_EN is defined, flags received parity
// mismatches and counts them in a saturating counter.
// Ports:
//   clk, rst                         - clock, async active-high reset
//   impar                            - parity mode, latched on a frame's first word
//   in_valid/in_ready/in_data/in_last/in_par   - input stream
//   out_valid/out_ready/out_data/out_par/out_last/out_err - output stream
//   frame_valid/frame_par/frame_words/frame_ovf - per-frame result
//   err_count                        - saturating mismatch count
// Macro: PARIDADE_CHECK_EN enables the received-parity check.
module paridade_quadro
    import paridade_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned MAX_FRAME = 16,
    parameter  int unsigned ERR_W     = 8,
    localparam int unsigned CNT_W     = $clog2(MAX_FRAME + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             impar,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_last,
    output logic             out_err,
    output logic             frame_valid,
    output logic             frame_par,
    output logic [CNT_W-1:0] frame_words,
    output logic             frame_ovf,
    output logic [ERR_W-1:0] err_count
);

    estado_t          state_q, state_d;
    logic             mode_q, mode_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_par_q, out_par_d;
    logic             out_last_q, out_last_d;
    logic             out_err_q, out_err_d;

    logic             frame_valid_q, frame_valid_d;
    logic             frame_par_q, frame_par_d;
    logic [CNT_W-1:0] frame_words_q, frame_words_d;
    logic             frame_ovf_q, frame_ovf_d;

    logic             accept_c;
    logic             mode_eff_c;
    logic             word_par_c;
    logic             mismatch_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             acc_inc_c;
    logic             fecha_c;

    // Single output register: refill whenever it is empty or being drained.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // The first word of a frame uses the live mode; later words the latched one.
    assign mode_eff_c = (state_q == OCIOSO) ? impar : mode_q;

    paridade_palavra #(.WIDTH(WIDTH)) u_palavra (
        .data  (in_data),
        .modo  (mode_eff_c),
        .par_c (word_par_c)
    );

    // Raw XOR of the word is the mode-adjusted parity with the mode removed.
    assign acc_inc_c = acc_q ^ word_par_c ^ mode_eff_c;
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign fecha_c   = in_last || (cnt_inc_c == CNT_W'(MAX_FRAME));

    // Next-state: frame tracking and output register load/drain
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_par_d     = out_par_q;
        out_last_d    = out_last_q;
        out_err_d     = out_err_q;
        frame_valid_d = 1'b0;
        frame_par_d   = frame_par_q;
        frame_words_d = frame_words_q;
        frame_ovf_d   = frame_ovf_q;

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_par_d   = word_par_c;
            out_last_d  = fecha_c;
            out_err_d   = mismatch_c;
            if (fecha_c) begin
                state_d       = OCIOSO;
                acc_d         = 1'b0;
                cnt_d         = '0;
                frame_valid_d = 1'b1;
                frame_par_d   = acc_inc_c ^ mode_eff_c;
                frame_words_d = cnt_inc_c;
                frame_ovf_d   = !in_last;
            end else begin
                state_d = QUADRO;
                mode_d  = mode_eff_c;
                acc_d   = acc_inc_c;
                cnt_d   = cnt_inc_c;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= OCIOSO;
            mode_q        <= MODO_PAR;
            acc_q         <= 1'b0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_par_q     <= 1'b0;
            out_last_q    <= 1'b0;
            out_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_par_q   <= 1'b0;
            frame_words_q <= '0;
            frame_ovf_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_par_q     <= out_par_d;
            out_last_q    <= out_last_d;
            out_err_q     <= out_err_d;
            frame_valid_q <= frame_valid_d;
            frame_par_q   <= frame_par_d;
            frame_words_q <= frame_words_d;
            frame_ovf_q   <= frame_ovf_d;
        end
    end

`ifdef PARIDADE_CHECK_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    assign mismatch_c = (in_par != word_par_c);

    // Saturating mismatch counter; only reset clears it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept_c && mismatch_c && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    logic unused_in_par;
    assign unused_in_par = in_par;
    assign mismatch_c    = 1'b0;
    assign err_count     = '0;
`endif

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_par     = out_par_q;
    assign out_last    = out_last_q;
    assign out_err     = out_err_q;
    assign frame_valid = frame_valid_q;
    assign frame_par   = frame_par_q;
    assign frame_words = frame_words_q;
    assign frame_ovf   = frame_ovf_q;

endmodule

// File: tb/tb_paridade_quadro.sv
// tb_paridade_quadro: bench for paridade_quadro with a per-cycle reference
// model (bit counting per word/frame) plus directed literal expectations.
module tb_paridade_quadro;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_FRAME = 16;
    localparam int unsigned ERR_W     = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int          ERR_MAX   = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             impar;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_par;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_par;
    logic             out_last;
    logic             out_err;
    logic             frame_valid;
    logic             frame_par;
    logic [CNT_W-1:0] frame_words;
    logic             frame_ovf;
    logic [ERR_W-1:0] err_count;

    paridade_quadro #(.WIDTH(WIDTH), .MAX_FRAME(MAX_FRAME), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .impar(impar),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_par(in_par),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_par(out_par), .out_last(out_last), .out_err(out_err),
        .frame_valid(frame_valid), .frame_par(frame_par),
        .frame_words(frame_words), .frame_ovf(frame_ovf),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observed beats and frame results, for directed literal checks
    typedef struct packed { logic [7:0] d; logic p; logic l; logic e; } beat_t;
    typedef struct packed { logic p; logic [4:0] w; logic o; } frm_t;
    beat_t outq[$];
    frm_t  fq[$];

    // Reference model state
    bit       m_open;
    bit       m_mode;
    int       m_words, m_ones, m_err;
    bit       e_ir, e_ov, e_op, e_ol, e_oe, e_fv, e_fp, e_fo;
    bit [7:0] e_od;
    int       e_fw;

    // Per-cycle compare against the model, then advance the model by the
    // transfer that the coming rising edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            m_open = 0; m_mode = 0; m_words = 0; m_ones = 0; m_err = 0;
            e_ov = 0; e_od = '0; e_op = 0; e_ol = 0; e_oe = 0;
            e_fv = 0; e_fp = 0; e_fw = 0; e_fo = 0;
        end
        e_ir = !rst && (!e_ov || out_ready);
        chk("in_ready",    int'(in_ready),    int'(e_ir));
        chk("out_valid",   int'(out_valid),   int'(e_ov));
        chk("out_data",    int'(out_data),    int'(e_od));
        chk("out_par",     int'(out_par),     int'(e_op));
        chk("out_last",    int'(out_last),    int'(e_ol));
        chk("out_err",     int'(out_err),     int'(e_oe));
        chk("frame_valid", int'(frame_valid), int'(e_fv));
        chk("frame_par",   int'(frame_par),   int'(e_fp));
        chk("frame_words", int'(frame_words), e_fw);
        chk("frame_ovf",   int'(frame_ovf),   int'(e_fo));
        chk("err_count",   int'(err_count),   m_err);

        if (!rst && out_valid && out_ready) outq.push_back({out_data, out_par, out_last, out_err});
        if (frame_valid) fq.push_back({frame_par, frame_words, frame_ovf});

        if (!rst) begin
            e_fv = 0;
            if (in_valid && e_ir) begin
                bit md, p, close;
                int ones;
                md    = m_open ? m_mode : impar;
                ones  = $countones(in_data);
                p     = ((ones + int'(md)) % 2) == 1;
                m_words++;
                m_ones += ones;
                close = in_last || (m_words == MAX_FRAME);
                e_ov = 1; e_od = in_data; e_op = p; e_ol = close;
`ifdef PARIDADE_CHECK_EN
                e_oe = (in_par != p);
                if (e_oe && m_err < ERR_MAX) m_err++;
`else
                e_oe = 0;
`endif
                if (close) begin
                    e_fv = 1;
                    e_fp = ((m_ones + int'(md)) % 2) == 1;
                    e_fw = m_words;
                    e_fo = !in_last;
                    m_open = 0; m_words = 0; m_ones = 0;
                end else begin
                    m_open = 1; m_mode = md;
                end
            end else if (out_ready) begin
                e_ov = 0;
            end
        end
    end

    // Consumer: random backpressure, overridable by a stall request
    int rdy_pct = 100;
    bit stall   = 0;
    always @(posedge clk) begin
        #1;
        out_ready = !stall && ($urandom_range(99) < rdy_pct);
    end

    // Drive one word; called and returns at posedge+1.
    task automatic send(input logic [7:0] d, input logic last, input logic md, input logic pb);
        int budget = 0;
        bit ok;
        in_valid = 1; in_data = d; in_last = last; impar = md; in_par = pb;
        do begin
            @(negedge clk);
            ok = in_ready;
            budget++;
            @(posedge clk); #1;
        end while (!ok && budget < 200);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        rdy_pct = 100;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        outq.delete();
        fq.delete();
    endtask

    initial begin
        logic [7:0] held;
        rst = 1; impar = 0; in_valid = 0; in_data = '0; in_last = 0; in_par = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready), 1);
        @(posedge clk); #1;

        // Even frame {01,03,07}: word parities 1,0,1; frame parity 1^0^1 = 0
        clear_logs();
        send(8'h01, 0, 0, 0); send(8'h03, 0, 0, 0); send(8'h07, 1, 0, 0);
        drain();
        chk("f1_beats", outq.size(), 3);
        chk("f1_fcount", fq.size(), 1);
        if (outq.size() == 3) begin
            chk("f1_par0", int'(outq[0].p), 1);
            chk("f1_par1", int'(outq[1].p), 0);
            chk("f1_par2", int'(outq[2].p), 1);
            chk("f1_last2", int'(outq[2].l), 1);
        end
        if (fq.size() == 1) begin
            chk("f1_fpar", int'(fq[0].p), 0);
            chk("f1_fwords", int'(fq[0].w), 3);
            chk("f1_fovf", int'(fq[0].o), 0);
        end

        // Odd single word 0x00, then a 2-word frame that toggles impar mid-frame
        clear_logs();
        send(8'h00, 1, 1, 0);
        send(8'h01, 0, 0, 0); send(8'h01, 1, 1, 0);
        drain();
        if (outq.size() == 3 && fq.size() == 2) begin
            chk("f2_par", int'(outq[0].p), 1);
            chk("f2_fpar", int'(fq[0].p), 1);
            chk("f2_fwords", int'(fq[0].w), 1);
            chk("f3_par1", int'(outq[2].p), 1);
            chk("f3_fpar", int'(fq[1].p), 0);
        end else chk("f2_counts", outq.size() * 10 + fq.size(), 32);

        // 16 x 0xFF without last: forced close, then a fresh frame
        clear_logs();
        for (int i = 0; i < 16; i++) send(8'hFF, 0, 0, 0);
        send(8'h03, 1, 0, 0);
        drain();
        if (outq.size() == 17 && fq.size() == 2) begin
            chk("ovf_last14", int'(outq[14].l), 0);
            chk("ovf_last15", int'(outq[15].l), 1);
            chk("ovf_fwords", int'(fq[0].w), 16);
            chk("ovf_fovf", int'(fq[0].o), 1);
            chk("ovf_fpar", int'(fq[0].p), 0);
            chk("ovf_next_words", int'(fq[1].w), 1);
            chk("ovf_next_ovf", int'(fq[1].o), 0);
        end else chk("ovf_counts", outq.size() * 10 + fq.size(), 172);

        // Backpressure: 5-cycle stall mid-stream, no loss or duplication
        clear_logs();
        fork
            for (int i = 0; i < 6; i++) send(8'(8'h10 + i), (i == 5), 0, 0);
            begin
                repeat (2) @(posedge clk);
                stall = 1;
                @(negedge clk);
                held = out_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(in_ready), 0);
                    chk("stall_hold", int'(out_data), int'(held));
                end
                stall = 0;
            end
        join
        drain();
        chk("stall_beats", outq.size(), 6);
        if (outq.size() == 6)
            for (int i = 0; i < 6; i++) chk("stall_order", int'(outq[i].d), 16 + i);

        // 300 words with wrong received parity
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send(d, (i % 10 == 9), 0, ~(^d));
        end
        drain();
`ifdef PARIDADE_CHECK_EN
        chk("err_saturated", int'(err_count), 255);
`else
        chk("err_tied", int'(err_count), 0);
`endif

        // Reset in the middle of a frame
        send(8'h11, 0, 0, 0); send(8'h22, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_frame_words", int'(frame_words), 0);
        @(posedge clk); #1 rst = 0;
        clear_logs();
        send(8'h05, 1, 0, 0);
        drain();
        chk("post_rst_fcount", fq.size(), 1);
        if (fq.size() == 1) begin
            chk("post_rst_fwords", int'(fq[0].w), 1);
            chk("post_rst_fpar", int'(fq[0].p), 0);
        end

        // Random traffic with gaps and backpressure
        rdy_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(8'($urandom), ($urandom_range(4) == 0), 1'($urandom), 1'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
